pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the RV32IM core.
- Decides each cycle whether the PC, IF/ID and ID/EX registers advance, stall or flush.
- Detects load-use RAW hazards between the decode and execute stages.
- Sequences the multi-cycle divider: start, wait, write-back, restart fetch at pc+4.
- Sits beside the decoder and execute stage and drives the hold and flush inputs of all pipeline registers.

## Interface
Parameters:
- `DIV_TIMEOUT`, 64: cycle limit for the divider; on expiry, write-back is suppressed and the refetch still occurs.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-low reset
- `id_reg1_raddr_i`  in  5  rs1 address read by decode; 0 = unused
- `id_reg2_raddr_i`  in  5  rs2 address read by decode; 0 = unused
- `id_reg_we_i`  in  1  decode instruction writes rd
- `id_reg_waddr_i`  in  5  decode rd
- `id_is_load_i`  in  1  decode instruction is LB/LH/LW/LBU/LHU
- `id_is_div_i`  in  1  decode instruction is DIV/DIVU/REM/REMU
- `id_inst_addr_i`  in  32  decode instruction address
- `ex_jump_flag_i`  in  1  execute-stage taken branch/jump
- `ex_jump_addr_i`  in  32  execute-stage target
- `hold_req_i`  in  1  external bus/debug hold request
- `div_done_i`  in  1  divider result valid, 1-cycle pulse
- `hold_pc_o`  out  1  freeze PC
- `hold_if_o`  out  1  freeze IF/ID
- `flush_if_o`  out  1  IF/ID loads NOP
- `flush_id_o`  out  1  ID/EX loads NOP (bubble)
- `jump_flag_o`  out  1  redirect PC
- `jump_addr_o`  out  32  redirect target
- `div_start_o`  out  1  divider start pulse
- `div_busy_o`  out  1  divider sequence in progress
- `div_we_o`  out  1  write-back enable for divider result
- `div_waddr_o`  out  5  divider destination register

## Operation
States: IDLE, DIV_WAIT, DIV_WB.

Registered EX-stage tags, updated every cycle the ID/EX register advances:
- `ex_load_q`, `ex_waddr_q` from the decode inputs.
- Cleared to 0 when a bubble is inserted.

Load-use stall, evaluated in IDLE only:
- Condition: `ex_load_q`, `ex_waddr_q != 0`, and (`ex_waddr_q` == `id_reg1_raddr_i` or `ex_waddr_q` == `id_reg2_raddr_i`).
- Response: `hold_pc_o = 1`, `hold_if_o = 1`, `flush_id_o = 1` for exactly one cycle.

Divider accept and wait:
- Accept: IDLE, `id_is_div_i = 1`, no higher-priority event.
- On accept: capture rd into `div_waddr_q` and `id_inst_addr_i + 4` into `div_ret_q`; go to DIV_WAIT.
- Next cycle: `div_start_o` pulses high for 1 cycle.
- In DIV_WAIT: `hold_pc_o = 1` and `hold_if_o = 1`; `flush_id_o = 1` each cycle; timeout counter increments.
- Exit DIV_WAIT on `div_done_i` or when the counter reaches `DIV_TIMEOUT-1`; go to DIV_WB.

DIV_WB (one cycle, then IDLE):
- `div_we_o = 1` only if exit was by `div_done_i`.
- `jump_flag_o = 1`, `jump_addr_o = div_ret_q`.
- `flush_if_o = 1`, `flush_id_o = 1`.
- `div_waddr_o` holds `div_waddr_q` throughout DIV_WAIT and DIV_WB.

Priority, highest first:
1. `ex_jump_flag_i`, IDLE only: `jump_flag_o = 1`, `jump_addr_o = ex_jump_addr_i`, `flush_if_o = 1`, `flush_id_o = 1`. Suppresses div accept and load-use stall.
2. `hold_req_i`: `hold_pc_o = 1`, `hold_if_o = 1`, `flush_id_o = 1`.
   - In IDLE, div accept is blocked.
   - In DIV_WAIT, the counter keeps running.
   - In DIV_WB, no delay: write-back and redirect still complete.
3. Divider sequence.
4. Load-use stall.

Other rules:
- `ex_jump_flag_i` is ignored in DIV_WAIT and DIV_WB; the held pipeline cannot produce one.
- `div_busy_o = 1` in DIV_WAIT and DIV_WB.
- `div_ret_q` addition wraps modulo 2^32.
- `div_done_i` outside DIV_WAIT is ignored.

## Timing
- Reset asserted: state IDLE; all outputs 0; `jump_addr_o` and `div_waddr_o` = 0; all internal registers cleared.
- Reset may be asserted mid-sequence; the divider result is then discarded.
- Hold, flush and jump outputs are combinational from state, tags and inputs. `div_start_o` is registered.
- Divider sequence: accept at cycle N, `div_start_o` at N+1, `div_done_i` at N+k, DIV_WB at N+k+1, IDLE at N+k+2.
- `div_done_i` in the same cycle as `div_start_o` is legal: DIV_WB follows at N+2.
- Load-use stall costs 1 cycle. The stalled instruction re-evaluates with `ex_load_q = 0` and proceeds.

## Structure
- Add to `defines.sv`: state encoding (`PipeCtrlIdle`, `PipeCtrlDivWait`, `PipeCtrlDivWb`) and `DivTimeoutDefault`.
- Reuse the existing `ZeroWord`, `ZeroReg`, `WriteEnable` and `WriteDisable`.
- One sub-module, `raw_detect`: combinational comparator of one write address against two read addresses, with the x0 exclusion.

## Test plan
- Load-use: LW x5 then ADD x6,x5,x1 -> one cycle of `hold_pc_o`, `hold_if_o`, `flush_id_o`; no stall when the consumer reads only x0 or when the load's rd = x0.
- Divider: DIV x7 at 0x100, `div_done_i` 12 cycles after `div_start_o` -> `div_we_o = 1`, `div_waddr_o = 7`, `jump_addr_o = 0x104`, then IDLE.
- Jump vs divider: `ex_jump_flag_i` to 0x200 in the same cycle the decode instruction is a DIV -> redirect to 0x200, no `div_start_o`.
- Timeout: `DIV_TIMEOUT = 8`, no `div_done_i` -> DIV_WB after 8 DIV_WAIT cycles with `div_we_o = 0` and `jump_flag_o = 1`.
- Wrap: DIV at 0xFFFFFFFC -> `jump_addr_o = 0x00000000`.
- Reset: drop `rst` during DIV_WAIT -> all outputs 0 immediately; a stale `div_done_i` after release is ignored.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and constants for the pipeline sequencing controller.
// No logic, so no latency and no backpressure of its own.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PipeCtrlIdle    = 2'd0,
    PipeCtrlDivWait = 2'd1,
    PipeCtrlDivWb   = 2'd2
  } pipe_state_e;

  localparam int          DivTimeoutDefault = 64;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic [4:0]  ZeroReg           = 5'd0;
  localparam logic        WriteEnable       = 1'b1;
  localparam logic        WriteDisable      = 1'b0;
  localparam logic [31:0] InstBytes         = 32'd4;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + InstBytes;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode/execute/divider signals seen by the pipeline controller.
// master = surrounding core, slave = pipe_ctrl.
interface pipe_ctrl_if;
  logic [4:0]  id_reg1_raddr_i;
  logic [4:0]  id_reg2_raddr_i;
  logic        id_reg_we_i;
  logic [4:0]  id_reg_waddr_i;
  logic        id_is_load_i;
  logic        id_is_div_i;
  logic [31:0] id_inst_addr_i;
  logic        ex_jump_flag_i;
  logic [31:0] ex_jump_addr_i;
  logic        hold_req_i;
  logic        div_done_i;
  logic        hold_pc_o;
  logic        hold_if_o;
  logic        flush_if_o;
  logic        flush_id_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        div_start_o;
  logic        div_busy_o;
  logic        div_we_o;
  logic [4:0]  div_waddr_o;

  modport master (
    output id_reg1_raddr_i, id_reg2_raddr_i, id_reg_we_i, id_reg_waddr_i,
           id_is_load_i, id_is_div_i, id_inst_addr_i, ex_jump_flag_i,
           ex_jump_addr_i, hold_req_i, div_done_i,
    input  hold_pc_o, hold_if_o, flush_if_o, flush_id_o, jump_flag_o,
           jump_addr_o, div_start_o, div_busy_o, div_we_o, div_waddr_o
  );

  modport slave (
    input  id_reg1_raddr_i, id_reg2_raddr_i, id_reg_we_i, id_reg_waddr_i,
           id_is_load_i, id_is_div_i, id_inst_addr_i, ex_jump_flag_i,
           ex_jump_addr_i, hold_req_i, div_done_i,
    output hold_pc_o, hold_if_o, flush_if_o, flush_id_o, jump_flag_o,
           jump_addr_o, div_start_o, div_busy_o, div_we_o, div_waddr_o
  );
endinterface

// File: rtl/pipe_ctrl_raw_detect.sv
// Flags a read-after-write match of one write address against two read ports.
// Purely combinational; x0 never hazards since it is hard-wired to zero.
module raw_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] waddr,
  input  logic [4:0] raddr1,
  input  logic [4:0] raddr2,
  output logic       hit
);

  assign hit = (waddr != ZeroReg) && ((waddr == raddr1) || (waddr == raddr2));

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/redirect sequencing for the RV32IM pipeline, incl. multi-cycle divide.
// Hold/flush/jump are same-cycle combinational; div_start_o lags accept by one cycle.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = DivTimeoutDefault
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  localparam int             CntW    = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_TIMEOUT - 1);

  pipe_state_e     state_q;
  logic            ex_load_q;
  logic [4:0]      ex_waddr_q;
  logic [4:0]      div_waddr_q;
  logic [31:0]     div_ret_q;
  logic [CntW-1:0] cnt_q;
  logic            done_q;
  logic            div_start_q;

  logic        raw_hit;
  logic        div_accept;
  logic        wait_exit;
  logic        hold_pc, hold_if, flush_if, flush_id, jump_flag;
  logic        div_we, div_busy;
  logic [31:0] jump_addr;
  logic [4:0]  div_waddr;

  raw_detect u_raw_detect (
    .waddr  (ex_waddr_q),
    .raddr1 (bus.id_reg1_raddr_i),
    .raddr2 (bus.id_reg2_raddr_i),
    .hit    (raw_hit)
  );

  always_comb begin
    hold_pc    = 1'b0;
    hold_if    = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    jump_flag  = 1'b0;
    jump_addr  = ZeroWord;
    div_we     = WriteDisable;
    div_busy   = 1'b0;
    div_waddr  = ZeroReg;
    div_accept = 1'b0;
    wait_exit  = bus.div_done_i || (cnt_q == CntLast);
    unique case (state_q)
      PipeCtrlIdle: begin
        if (bus.ex_jump_flag_i) begin
          jump_flag = 1'b1;
          jump_addr = bus.ex_jump_addr_i;
          flush_if  = 1'b1;
          flush_id  = 1'b1;
        end else if (bus.hold_req_i) begin
          hold_pc  = 1'b1;
          hold_if  = 1'b1;
          flush_id = 1'b1;
        end else if (bus.id_is_div_i) begin
          div_accept = 1'b1;
        end else if (ex_load_q && raw_hit) begin
          hold_pc  = 1'b1;
          hold_if  = 1'b1;
          flush_id = 1'b1;
        end
      end
      PipeCtrlDivWait: begin
        hold_pc   = 1'b1;
        hold_if   = 1'b1;
        flush_id  = 1'b1;
        div_busy  = 1'b1;
        div_waddr = div_waddr_q;
      end
      PipeCtrlDivWb: begin
        // Redirect and write-back always complete here; a hold only adds freezes.
        div_busy  = 1'b1;
        div_waddr = div_waddr_q;
        div_we    = done_q ? WriteEnable : WriteDisable;
        jump_flag = 1'b1;
        jump_addr = div_ret_q;
        flush_if  = 1'b1;
        flush_id  = 1'b1;
        hold_pc   = bus.hold_req_i;
        hold_if   = bus.hold_req_i;
      end
      default: ;
    endcase
  end

  // Outputs are forced low for the whole time reset is held, not just after the edge.
  assign bus.hold_pc_o   = rst & hold_pc;
  assign bus.hold_if_o   = rst & hold_if;
  assign bus.flush_if_o  = rst & flush_if;
  assign bus.flush_id_o  = rst & flush_id;
  assign bus.jump_flag_o = rst & jump_flag;
  assign bus.jump_addr_o = rst ? jump_addr : ZeroWord;
  assign bus.div_we_o    = rst & div_we;
  assign bus.div_busy_o  = rst & div_busy;
  assign bus.div_waddr_o = rst ? div_waddr : ZeroReg;
  assign bus.div_start_o = div_start_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PipeCtrlIdle;
      ex_load_q   <= 1'b0;
      ex_waddr_q  <= ZeroReg;
      div_waddr_q <= ZeroReg;
      div_ret_q   <= ZeroWord;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      div_start_q <= div_accept;
      if (flush_id) begin
        ex_load_q  <= 1'b0;
        ex_waddr_q <= ZeroReg;
      end else begin
        ex_load_q  <= bus.id_is_load_i;
        ex_waddr_q <= bus.id_reg_we_i ? bus.id_reg_waddr_i : ZeroReg;
      end
      unique case (state_q)
        PipeCtrlIdle: begin
          if (div_accept) begin
            state_q     <= PipeCtrlDivWait;
            div_waddr_q <= bus.id_reg_waddr_i;
            div_ret_q   <= next_pc(bus.id_inst_addr_i);
            cnt_q       <= '0;
            done_q      <= 1'b0;
          end
        end
        PipeCtrlDivWait: begin
          if (wait_exit) begin
            state_q <= PipeCtrlDivWb;
            done_q  <= bus.div_done_i;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        PipeCtrlDivWb: state_q <= PipeCtrlIdle;
        default:       state_q <= PipeCtrlIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: load-use vector table, divider sequences with a write-back
// scoreboard, jump/hold priority, timeout on a second instance, and mid-sequence reset.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if b();
  pipe_ctrl_if b8();

  pipe_ctrl #(.DIV_TIMEOUT(64)) dut  (.clk(clk), .rst(rst), .bus(b));
  pipe_ctrl #(.DIV_TIMEOUT(8))  dut8 (.clk(clk), .rst(rst), .bus(b8));

  assign b8.id_reg1_raddr_i = b.id_reg1_raddr_i;
  assign b8.id_reg2_raddr_i = b.id_reg2_raddr_i;
  assign b8.id_reg_we_i     = b.id_reg_we_i;
  assign b8.id_reg_waddr_i  = b.id_reg_waddr_i;
  assign b8.id_is_load_i    = b.id_is_load_i;
  assign b8.id_is_div_i     = b.id_is_div_i;
  assign b8.id_inst_addr_i  = b.id_inst_addr_i;
  assign b8.ex_jump_flag_i  = b.ex_jump_flag_i;
  assign b8.ex_jump_addr_i  = b.ex_jump_addr_i;
  assign b8.hold_req_i      = b.hold_req_i;
  assign b8.div_done_i      = b.div_done_i;

  localparam logic [6:0] HPC = 7'b1000000;
  localparam logic [6:0] HIF = 7'b0100000;
  localparam logic [6:0] FIF = 7'b0010000;
  localparam logic [6:0] FID = 7'b0001000;
  localparam logic [6:0] JMP = 7'b0000100;
  localparam logic [6:0] DST = 7'b0000010;
  localparam logic [6:0] BSY = 7'b0000001;
  localparam logic [6:0] STALL = HPC | HIF | FID;
  localparam logic [6:0] REDIR = FIF | FID | JMP;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] addr;
  } wb_t;
  wb_t sb[$];

  typedef struct {
    logic       p_load;
    logic [4:0] p_rd;
    logic [4:0] c_r1;
    logic [4:0] c_r2;
    logic       c_jump;
    logic       c_hreq;
    logic [6:0] exp_ctl;
  } lu_vec_t;
  lu_vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl();
    return {b.hold_pc_o, b.hold_if_o, b.flush_if_o, b.flush_id_o,
            b.jump_flag_o, b.div_start_o, b.div_busy_o};
  endfunction

  function automatic logic [6:0] ctl8();
    return {b8.hold_pc_o, b8.hold_if_o, b8.flush_if_o, b8.flush_id_o,
            b8.jump_flag_o, b8.div_start_o, b8.div_busy_o};
  endfunction

  task automatic drive_idle();
    b.id_reg1_raddr_i = 5'd0;
    b.id_reg2_raddr_i = 5'd0;
    b.id_reg_we_i     = 1'b0;
    b.id_reg_waddr_i  = 5'd0;
    b.id_is_load_i    = 1'b0;
    b.id_is_div_i     = 1'b0;
    b.id_inst_addr_i  = 32'h0;
    b.ex_jump_flag_i  = 1'b0;
    b.ex_jump_addr_i  = 32'h0;
    b.hold_req_i      = 1'b0;
    b.div_done_i      = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    drive_idle();
  endtask

  task automatic drive_div(input logic [4:0] rd, input logic [31:0] addr);
    b.id_is_div_i    = 1'b1;
    b.id_reg_we_i    = 1'b1;
    b.id_reg_waddr_i = rd;
    b.id_inst_addr_i = addr;
  endtask

  // k = cycles between div_start_o and div_done_i (0 = same cycle)
  task automatic div_seq(input logic [4:0] rd, input logic [31:0] addr, input int k);
    wb_t e;
    tick(); drive_div(rd, addr); #2;
    check("div_accept_ctl", ctl(), 7'd0);
    e.waddr = rd; e.we = 1'b1; e.addr = addr + 32'd4;
    sb.push_back(e);
    tick(); if (k == 0) b.div_done_i = 1'b1; #2;
    check("div_start_ctl", ctl(), STALL | DST | BSY);
    check("div_wait_waddr", b.div_waddr_o, rd);
    for (int j = 1; j <= k; j++) begin
      tick(); if (j == k) b.div_done_i = 1'b1; #2;
      check("div_wait_ctl", ctl(), STALL | BSY);
    end
    tick(); #2;
    check("div_wb_ctl", ctl(), REDIR | BSY);
    tick(); #2;
    check("div_idle_ctl", ctl(), 7'd0);
    check("div_idle_waddr", b.div_waddr_o, 5'd0);
  endtask

  // Write-back scoreboard: every DIV_WB cycle must match the oldest accepted divide.
  always begin
    wb_t e;
    @(negedge clk);
    #3;
    if (rst && b.div_busy_o && b.jump_flag_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got waddr %0d with empty queue", b.div_waddr_o);
      end else begin
        e = sb.pop_front();
        check("wb_waddr", b.div_waddr_o, e.waddr);
        check("wb_we", b.div_we_o, e.we);
        check("wb_jump_addr", b.jump_addr_o, e.addr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5,  5'd5,  5'd1,  1'b0, 1'b0, STALL};
    vecs[1] = '{1'b1, 5'd5,  5'd1,  5'd5,  1'b0, 1'b0, STALL};
    vecs[2] = '{1'b1, 5'd5,  5'd0,  5'd0,  1'b0, 1'b0, 7'd0};
    vecs[3] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 7'd0};
    vecs[4] = '{1'b0, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0, 7'd0};
    vecs[5] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, STALL};
    vecs[6] = '{1'b1, 5'd5,  5'd6,  5'd7,  1'b0, 1'b0, 7'd0};
    vecs[7] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, REDIR};
    vecs[8] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, STALL};
    vecs[9] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b1, STALL};

    // Reset: outputs low even with a jump request present.
    drive_idle();
    b.ex_jump_flag_i = 1'b1;
    b.ex_jump_addr_i = 32'h1234;
    #2;
    check("reset_ctl", ctl(), 7'd0);
    check("reset_jump_addr", b.jump_addr_o, 32'h0);
    check("reset_waddr", b.div_waddr_o, 5'd0);
    check("reset_ctl8", ctl8(), 7'd0);
    tick(); tick(); rst = 1'b1;

    // Load-use table: neutral, producer, consumer, consumer re-evaluation.
    for (int i = 0; i < 10; i++) begin
      tick(); #2;
      tick();
      b.id_is_load_i = vecs[i].p_load;
      b.id_reg_we_i = 1'b1;
      b.id_reg_waddr_i = vecs[i].p_rd;
      #2;
      check($sformatf("lu%0d_producer", i), ctl(), 7'd0);
      tick();
      b.id_reg1_raddr_i = vecs[i].c_r1;
      b.id_reg2_raddr_i = vecs[i].c_r2;
      b.ex_jump_flag_i = vecs[i].c_jump;
      b.ex_jump_addr_i = 32'h200;
      b.hold_req_i = vecs[i].c_hreq;
      #2;
      check($sformatf("lu%0d_consumer", i), ctl(), vecs[i].exp_ctl);
      check($sformatf("lu%0d_jump_addr", i), b.jump_addr_o,
            vecs[i].c_jump ? 32'h200 : 32'h0);
      tick();
      b.id_reg1_raddr_i = vecs[i].c_r1;
      b.id_reg2_raddr_i = vecs[i].c_r2;
      #2;
      check($sformatf("lu%0d_reeval", i), ctl(), 7'd0);
    end

    // Divider: done 12 cycles after start, then done coincident with start at wrap address.
    div_seq(5'd7, 32'h0000_0100, 12);
    div_seq(5'd3, 32'hFFFF_FFFC, 0);

    // Stale done in IDLE is ignored.
    tick(); b.div_done_i = 1'b1; #2;
    check("stale_done_ctl", ctl(), 7'd0);
    tick(); #2;
    check("stale_done_after", ctl(), 7'd0);
    check("stale_done_we", b.div_we_o, 1'b0);

    // Jump wins over a decode-stage divide.
    tick(); drive_div(5'd7, 32'h300);
    b.ex_jump_flag_i = 1'b1;
    b.ex_jump_addr_i = 32'h200;
    #2;
    check("jump_vs_div_ctl", ctl(), REDIR);
    check("jump_vs_div_addr", b.jump_addr_o, 32'h200);
    tick(); #2;
    check("jump_vs_div_next", ctl(), 7'd0);

    // Hold request blocks divider accept.
    tick(); drive_div(5'd7, 32'h300); b.hold_req_i = 1'b1; #2;
    check("hold_vs_div_ctl", ctl(), STALL);
    tick(); #2;
    check("hold_vs_div_next", ctl(), 7'd0);

    // Timeout on the DIV_TIMEOUT=8 instance.
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
    tick(); drive_div(5'd9, 32'h40); #2;
    check("to_accept_ctl", ctl8(), 7'd0);
    for (int j = 1; j <= 8; j++) begin
      tick(); #2;
      check($sformatf("to_wait%0d_ctl", j), ctl8(), STALL | BSY | ((j == 1) ? DST : 7'd0));
    end
    tick(); #2;
    check("to_wb_ctl", ctl8(), REDIR | BSY);
    check("to_wb_we", b8.div_we_o, 1'b0);
    check("to_wb_addr", b8.jump_addr_o, 32'h44);
    check("to_wb_waddr", b8.div_waddr_o, 5'd9);
    tick(); #2;
    check("to_idle_ctl", ctl8(), 7'd0);

    // Reset mid-DIV_WAIT; result discarded, stale done ignored afterwards.
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
    tick(); drive_div(5'd4, 32'h10); #2;
    tick(); #2;
    tick(); #2;
    check("rst_pre_ctl", ctl(), STALL | BSY);
    #1;
    rst = 1'b0;
    b.ex_jump_flag_i = 1'b1;
    b.ex_jump_addr_i = 32'h200;
    #1;
    check("rst_mid_ctl", ctl(), 7'd0);
    check("rst_mid_jump_addr", b.jump_addr_o, 32'h0);
    check("rst_mid_waddr", b.div_waddr_o, 5'd0);
    check("rst_mid_we", b.div_we_o, 1'b0);
    tick();
    tick(); rst = 1'b1; #2;
    tick(); b.div_done_i = 1'b1; #2;
    check("rst_stale_done_ctl", ctl(), 7'd0);
    tick(); #2;
    check("rst_after_ctl", ctl(), 7'd0);
    check("rst_after_we", b.div_we_o, 1'b0);

    tick(); tick();
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
